// File: rtl/led_pattern.sv
// Multi-channel LED driver: OFF/ON/BLINK/DIM per channel from a shared prescaler and PWM counter.
// One cycle registered latency to led_o/tick_o; no backpressure, config writes always accepted.
module led_pattern #(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 5_000_000,
    parameter int PWM_W    = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [PWM_W-1:0]  cfg_duty_i,
    output logic [NUM_CH-1:0] led_o,
    output logic              tick_o
);
    localparam int PR_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_DIM   = 2'b11
    } mode_e;

    logic [PR_W-1:0]   presc_q, presc_d;
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic [NUM_CH-1:0] blink_q, blink_d;
    mode_e             mode_q [NUM_CH];
    mode_e             mode_d [NUM_CH];
    logic [PWM_W-1:0]  duty_q [NUM_CH];
    logic [PWM_W-1:0]  duty_d [NUM_CH];

    always_comb begin
        presc_d = presc_q;
        pwm_d   = pwm_q;
        tick_d  = 1'b0;
        led_d   = '0;
        blink_d = blink_q;
        for (int k = 0; k < NUM_CH; k++) begin
            mode_d[k] = mode_q[k];
            duty_d[k] = duty_q[k];
        end

        if (en_i) begin
            tick_d  = (presc_q == PR_W'(TICK_DIV - 1));
            presc_d = tick_d ? '0 : presc_q + 1'b1;
            pwm_d   = pwm_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                unique case (mode_q[k])
                    MODE_OFF:   led_d[k] = 1'b0;
                    MODE_ON:    led_d[k] = 1'b1;
                    MODE_BLINK: led_d[k] = blink_q[k];
                    MODE_DIM:   led_d[k] = (pwm_q < duty_q[k]);
                    default:    led_d[k] = 1'b0;
                endcase
                if (tick_d) begin
                    blink_d[k] = ~blink_q[k];
                end
            end
        end

        // Out-of-range channel indices match no k and fall through untouched;
        // a write overrides a same-cycle blink toggle.
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_we_i && (cfg_ch_i == CH_W'(k))) begin
                mode_d[k]  = mode_e'(cfg_mode_i);
                duty_d[k]  = cfg_duty_i;
                blink_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            presc_q <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= '0;
            blink_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k] <= MODE_OFF;
                duty_q[k] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
            blink_q <= blink_d;
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k] <= mode_d[k];
                duty_q[k] <= duty_d[k];
            end
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;
endmodule

// File: tb/tb_led_pattern.sv
// Bench for led_pattern: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against an event-count model, plus directed literal pins.
module tb_led_pattern;
    localparam int TD = 4;
    localparam int PW = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, we;
    logic [1:0] ch, md;
    logic [3:0] dt;
    logic [3:0] led4;
    logic [2:0] led3;
    logic       tick4, tick3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_pattern #(.NUM_CH(4), .TICK_DIV(TD), .PWM_W(PW)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_we_i(we), .cfg_ch_i(ch),
        .cfg_mode_i(md), .cfg_duty_i(dt), .led_o(led4), .tick_o(tick4));

    led_pattern #(.NUM_CH(3), .TICK_DIV(TD), .PWM_W(PW)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_we_i(we), .cfg_ch_i(ch),
        .cfg_mode_i(md), .cfg_duty_i(dt), .led_o(led3), .tick_o(tick3));

    // Model: blink state is the parity of ticks seen since the channel's last write/reset;
    // prescaler and PWM phase are the enabled-cycle count modulo their periods.
    int   en_cnt, ntick;
    int   nch [2] = '{4, 3};
    int   m_mode [2][4];
    int   m_duty [2][4];
    int   m_tw   [2][4];
    logic [3:0] exp_led [2];
    logic exp_tick;
    bit   model_valid = 0;

    always @(posedge clk) begin
        bit tk;
        if (!rst_n) begin
            en_cnt = 0;
            ntick  = 0;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 4; k++) begin
                    m_mode[i][k] = 0; m_duty[i][k] = 0; m_tw[i][k] = 0;
                end
                exp_led[i] = '0;
            end
            exp_tick = 1'b0;
        end else begin
            tk = en && ((en_cnt % TD) == TD - 1);
            for (int i = 0; i < 2; i++) begin
                exp_led[i] = '0;
                for (int k = 0; k < nch[i]; k++) begin
                    if (en) begin
                        case (m_mode[i][k])
                            1:       exp_led[i][k] = 1'b1;
                            2:       exp_led[i][k] = ((ntick - m_tw[i][k]) % 2) == 1;
                            3:       exp_led[i][k] = (en_cnt % (1 << PW)) < m_duty[i][k];
                            default: exp_led[i][k] = 1'b0;
                        endcase
                    end
                end
            end
            exp_tick = tk;
            if (en) en_cnt++;
            if (tk) ntick++;
            if (we) begin
                for (int i = 0; i < 2; i++) begin
                    if (int'(ch) < nch[i]) begin
                        m_mode[i][ch] = int'(md);
                        m_duty[i][ch] = int'(dt);
                        m_tw[i][ch]   = ntick;
                    end
                end
            end
        end
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if ({led4, tick4} !== {exp_led[0], exp_tick}) begin
                miscompares++;
                $display("FAIL model4 t=%0t led=%b tick=%b expected led=%b tick=%b",
                         $time, led4, tick4, exp_led[0], exp_tick);
            end
            vectors++;
            if ({led3, tick3} !== {exp_led[1][2:0], exp_tick}) begin
                miscompares++;
                $display("FAIL model3 t=%0t led=%b tick=%b expected led=%b tick=%b",
                         $time, led3, tick3, exp_led[1][2:0], exp_tick);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [1:0] c, input logic [1:0] m, input logic [3:0] d);
        rst_n = r; en = e; we = w; ch = c; md = m; dt = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e);
        drive(1'b1, e, 1'b0, 2'd0, 2'd0, 4'd0);
    endtask

    initial begin
        int cnt;
        rst_n = 0; en = 0; we = 0; ch = 0; md = 0; dt = 0;

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
            check("rst_led", int'(led4), 0);
            check("rst_tick", int'(tick4), 0);
        end
        idle(1'b0);
        check("post_rst_led", int'(led4), 0);
        check("post_rst_tick", int'(tick4), 0);

        drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 4'd0);           // E1: ch0 BLINK
        idle(1'b1);                                            // E2
        idle(1'b1);                                            // E3
        check("tick_e3", int'(tick4), 0);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 4'd0);           // E4: tick + rewrite
        check("tick_e4", int'(tick4), 1);
        check("led0_e4", int'(led4[0]), 0);
        idle(1'b1);                                            // E5
        check("write_on_tick_led0", int'(led4[0]), 0);
        check("tick_e5", int'(tick4), 0);
        idle(1'b1); idle(1'b1); idle(1'b1);                    // E6..E8
        check("tick_e8", int'(tick4), 1);
        idle(1'b1);                                            // E9
        check("led0_e9", int'(led4[0]), 1);
        check("led_others_e9", int'(led4[3:1]), 0);

        drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 4'd4);            // ch1 DIM duty 4
        idle(1'b1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin idle(1'b1); cnt += int'(led4[1]); end
        check("dim4_count", cnt, 4);
        drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd3, 4'd0);
        idle(1'b1);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin idle(1'b1); cnt += int'(led4[1]); end
        check("dim0_count", cnt, 0);

        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            cnt += int'(tick4) + int'(led4 != 4'd0);
        end
        check("disabled_activity", cnt, 0);
        for (int i = 0; i < 12; i++) idle(1'b1);

        drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 4'd0);
        drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 4'd0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("pre_rst_on", int'(led4[1]), 1);
        drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 4'd0);
        check("midrst_led", int'(led4), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin idle(1'b1); cnt += int'(led4 != 4'd0); end
        check("after_rst_dark", cnt, 0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 7) == 0),
                  2'($urandom), 2'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
